// File: rtl/reg_file_sb.sv
// Integer register file: two combinational read ports, one write port,
// optional write-to-read forwarding and a per-register pending-write scoreboard.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter bit BYPASS = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] RFrs1,
  output logic [XLEN-1:0] RFrs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] DataWr,
  input  logic            RFWr,
  input  logic            IssueEn,
  input  logic [AW-1:0]   IssueRd,
  output logic            Rs1Busy,
  output logic            Rs2Busy,
  output logic [AW:0]     BusyCount
);

  localparam int unsigned DEPTH = 1 << AW;

  // Index 0 is the hardwired zero register; indices past NREGS do not exist.
  function automatic logic valid_idx(input logic [AW-1:0] i);
    return (i != '0) && (int'(i) < NREGS);
  endfunction

  logic [XLEN-1:0] rf [DEPTH];
  logic [DEPTH-1:0] busy;

  logic wr_ok, iss_ok, set_b, clr_b;
  logic fwd1, fwd2;

  always_comb begin
    wr_ok  = RFWr && valid_idx(rd);
    iss_ok = IssueEn && valid_idx(IssueRd);
    set_b  = iss_ok && !busy[IssueRd];
    clr_b  = wr_ok && busy[rd] && !(iss_ok && (IssueRd == rd));
    // Forwarding is held off during reset so the read ports stay at zero.
    fwd1   = BYPASS && !RST && wr_ok && (rd == rs1);
    fwd2   = BYPASS && !RST && wr_ok && (rd == rs2);
  end

  always_comb begin
    RFrs1   = '0;
    Rs1Busy = 1'b0;
    if (valid_idx(rs1)) begin
      RFrs1   = fwd1 ? DataWr : rf[rs1];
      Rs1Busy = !fwd1 && busy[rs1];
    end
  end

  always_comb begin
    RFrs2   = '0;
    Rs2Busy = 1'b0;
    if (valid_idx(rs2)) begin
      RFrs2   = fwd2 ? DataWr : rf[rs2];
      Rs2Busy = !fwd2 && busy[rs2];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) rf[i] <= '0;
      busy      <= '0;
      BusyCount <= '0;
    end else begin
      if (wr_ok) begin
        rf[rd]   <= DataWr;
        busy[rd] <= 1'b0;
      end
      // Issue follows the write so a same-index issue leaves the bit set.
      if (iss_ok) busy[IssueRd] <= 1'b1;
      BusyCount <= BusyCount + (AW+1)'(set_b) - (AW+1)'(clr_b);
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (NREGS=24 with forwarding, NREGS=32
// without) share one stimulus stream and are checked against array models.
module tb_reg_file_sb;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  rs1, rs2, rd, IssueRd;
  logic [31:0] DataWr;
  logic        RFWr, IssueEn;

  logic [31:0] q1 [2];
  logic [31:0] q2 [2];
  logic        b1 [2];
  logic        b2 [2];
  logic [5:0]  cnt [2];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  int nregs [2] = '{24, 32};
  bit byp   [2] = '{1'b1, 1'b0};
  logic [31:0] mrf   [2][32];
  bit          mbusy [2][32];

  always #5 CLK = ~CLK;

  reg_file_sb #(.XLEN(32), .NREGS(24), .BYPASS(1'b1)) u0 (
    .CLK(CLK), .RST(RST), .rs1(rs1), .rs2(rs2), .RFrs1(q1[0]), .RFrs2(q2[0]),
    .rd(rd), .DataWr(DataWr), .RFWr(RFWr), .IssueEn(IssueEn), .IssueRd(IssueRd),
    .Rs1Busy(b1[0]), .Rs2Busy(b2[0]), .BusyCount(cnt[0]));

  reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) u1 (
    .CLK(CLK), .RST(RST), .rs1(rs1), .rs2(rs2), .RFrs1(q1[1]), .RFrs2(q2[1]),
    .rd(rd), .DataWr(DataWr), .RFWr(RFWr), .IssueEn(IssueEn), .IssueRd(IssueRd),
    .Rs1Busy(b1[1]), .Rs2Busy(b2[1]), .BusyCount(cnt[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mvalid(int k, logic [4:0] i);
    return (i != 0) && (int'(i) < nregs[k]);
  endfunction

  function automatic logic [31:0] exp_data(int k, logic [4:0] i);
    if (RST || !mvalid(k, i)) return 32'h0;
    if (byp[k] && RFWr && rd == i) return DataWr;
    return mrf[k][i];
  endfunction

  function automatic logic exp_busy(int k, logic [4:0] i);
    if (RST || !mvalid(k, i)) return 1'b0;
    if (byp[k] && RFWr && rd == i) return 1'b0;
    return mbusy[k][i];
  endfunction

  function automatic int popcnt(int k);
    int s = 0;
    for (int i = 0; i < 32; i++) s += int'(mbusy[k][i]);
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        mrf[k][i]   = 32'h0;
        mbusy[k][i] = 1'b0;
      end
  endtask

  // A write retires the pending producer; an issue in the same cycle re-arms it.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (RFWr && mvalid(k, rd)) begin
        mrf[k][rd]   = DataWr;
        mbusy[k][rd] = 1'b0;
      end
      if (IssueEn && mvalid(k, IssueRd)) mbusy[k][IssueRd] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.RFrs1", k), 64'(q1[k]), 64'(exp_data(k, rs1)));
      chk($sformatf("u%0d.RFrs2", k), 64'(q2[k]), 64'(exp_data(k, rs2)));
      chk($sformatf("u%0d.Rs1Busy", k), 64'(b1[k]), 64'(exp_busy(k, rs1)));
      chk($sformatf("u%0d.Rs2Busy", k), 64'(b2[k]), 64'(exp_busy(k, rs2)));
      chk($sformatf("u%0d.BusyCount", k), 64'(cnt[k]), 64'(popcnt(k)));
    end
  endtask

  task automatic tick_check();
    @(negedge CLK);
    check_all();
  endtask

  task automatic tick_edge();
    @(posedge CLK);
    if (!RST) model_update();
    #1;
  endtask

  task automatic step();
    tick_check();
    tick_edge();
  endtask

  task automatic idle();
    RFWr = 1'b0; IssueEn = 1'b0; rd = '0; IssueRd = '0; DataWr = '0;
    rs1 = '0; rs2 = '0;
  endtask

  // Reset raised between edges, held across one rising edge, then released.
  task automatic pulse_reset();
    #1 RST = 1'b1;
    model_clear();
    #1 check_all();
    tick_check();
    tick_edge();
    RST = 1'b0;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 9));
  endfunction

  initial begin
    idle();
    RST = 1'b1;
    model_clear();
    #1 check_all();
    @(posedge CLK);
    #1 RST = 1'b0;

    for (int r = 1; r < 32; r++) begin
      idle();
      RFWr = 1'b1; rd = 5'(r); DataWr = $urandom;
      IssueEn = 1'($urandom_range(0, 1)); IssueRd = 5'($urandom_range(0, 31));
      step();
    end

    idle(); RFWr = 1'b1; rd = 5'd5; DataWr = 32'h0BADF00D;
    step();
    DataWr = 32'h12345678; rs1 = 5'd5; rs2 = 5'd5;
    tick_check();
    chk("byp_same_rs1", 64'(q1[0]), 64'h12345678);
    chk("byp_same_rs2", 64'(q2[0]), 64'h12345678);
    chk("nobyp_old", 64'(q1[1]), 64'h0BADF00D);
    tick_edge();
    idle(); rs1 = 5'd5;
    tick_check();
    chk("nobyp_next", 64'(q1[1]), 64'h12345678);
    tick_edge();

    idle(); RFWr = 1'b1; rd = 5'd5; DataWr = 32'h55555555; IssueEn = 1'b1;
    IssueRd = 5'd6; rs1 = 5'd5; rs2 = 5'd6;
    pulse_reset();
    idle(); rs1 = 5'd5; rs2 = 5'd6;
    tick_check();
    chk("rst_drop_u0", 64'(q1[0]), 64'h0);
    chk("rst_drop_u1", 64'(q1[1]), 64'h0);
    chk("rst_cnt", 64'(cnt[1]), 64'h0);
    tick_edge();

    idle(); RFWr = 1'b1; rd = 5'd0; DataWr = 32'hDEADBEEF; IssueEn = 1'b1; IssueRd = 5'd0;
    step();
    rd = 5'd30; IssueRd = 5'd30;
    step();
    idle(); rs1 = 5'd0; rs2 = 5'd30;
    tick_check();
    chk("x0_read", 64'(q1[0]), 64'h0);
    chk("oob_read", 64'(q2[0]), 64'h0);
    chk("oob_busy", 64'(b2[0]), 64'h0);
    chk("oob_cnt", 64'(cnt[0]), 64'h0);
    tick_edge();

    idle(); IssueEn = 1'b1; IssueRd = 5'd7;
    step();
    idle(); rs1 = 5'd7;
    tick_check();
    chk("sb_busy", 64'(b1[0]), 64'h1);
    chk("sb_cnt1", 64'(cnt[0]), 64'h1);
    tick_edge();
    RFWr = 1'b1; rd = 5'd7; DataWr = 32'hA5A50007;
    tick_check();
    chk("sb_fwd_busy", 64'(b1[0]), 64'h0);
    chk("sb_nofwd_busy", 64'(b1[1]), 64'h1);
    tick_edge();
    idle(); rs1 = 5'd7;
    tick_check();
    chk("sb_clr_busy", 64'(b1[0]), 64'h0);
    chk("sb_cnt0", 64'(cnt[0]), 64'h0);
    tick_edge();

    idle(); IssueEn = 1'b1; IssueRd = 5'd9;
    step();
    RFWr = 1'b1; rd = 5'd9; DataWr = 32'hCAFE0009;
    step();
    idle(); rs1 = 5'd9;
    tick_check();
    chk("iw_busy", 64'(b1[0]), 64'h1);
    chk("iw_data", 64'(q1[0]), 64'hCAFE0009);
    chk("iw_cnt", 64'(cnt[0]), 64'h1);
    tick_edge();
    IssueEn = 1'b1; IssueRd = 5'd3;
    step();
    step();
    idle();
    tick_check();
    chk("reissue_cnt", 64'(cnt[0]), 64'h2);
    tick_edge();

    for (int c = 0; c < 10000; c++) begin
      RFWr = 1'($urandom_range(0, 1)); rd = pick(); DataWr = $urandom;
      IssueEn = 1'($urandom_range(0, 1)); IssueRd = ($urandom_range(0, 3) == 0) ? rd : pick();
      rs1 = ($urandom_range(0, 3) == 0) ? rd : pick();
      rs2 = ($urandom_range(0, 3) == 0) ? IssueRd : pick();
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
